// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: merges the never-stalled pipeline write port with a small
// FIFO of multi-cycle results, squashing buffered writes overtaken by the pipeline.
module reg_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        regwrite,
  output logic [4:0]  wrreg,
  output logic [31:0] wrdata,
  output logic [31:0] pending_mask,
  output logic [2:0]  fifo_count
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] valid_next;
  logic [PW-1:0]    head, tail;
  logic [2:0]       count;

  logic pipe_eff, push, pop, head_live, push_valid;

  always_comb begin
    pipe_eff   = pipe_we && (pipe_rd != 5'd0);
    mc_ready   = count < DEPTH_C;
    push       = mc_valid && mc_ready;
    head_live  = (count != 3'd0) && ent_valid[head];
    // A live head yields to the pipeline; a squashed head drains regardless.
    pop        = (count != 3'd0) && !(head_live && pipe_eff);
    push_valid = (mc_rd != 5'd0) && !(pipe_eff && (pipe_rd == mc_rd));

    valid_next = ent_valid;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pipe_eff && (ent_rd[i] == pipe_rd)) valid_next[i] = 1'b0;
    end
    if (pop)  valid_next[head] = 1'b0;
    if (push) valid_next[tail] = push_valid;
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pending_mask[ent_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      regwrite  <= 1'b0;
      wrreg     <= '0;
      wrdata    <= '0;
    end else begin
      ent_valid <= valid_next;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count    <= count + {2'b00, push} - {2'b00, pop};
      regwrite <= pipe_eff || head_live;
      if (pipe_eff) begin
        wrreg  <= pipe_rd;
        wrdata <= pipe_data;
      end else if (head_live) begin
        wrreg  <= ent_rd[head];
        wrdata <= ent_data[head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[tail]   <= mc_rd;
      ent_data[tail] <= mc_data;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: queue-based reference model, expected writes are
// scoreboarded and popped by a monitor whenever regwrite is seen.
module tb_reg_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  reg_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ready(mc_ready), .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        v;
  } ent_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  ent_t q[$];
  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  bit   done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].v && q[i].rd != 5'd0) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  // Reference: the buffer is an ordered list; the pipeline always wins the port.
  task automatic step(input bit we, input logic [4:0] prd, input logic [31:0] pd,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                      input bit r);
    bit eff, acc, drain;
    ent_t e;
    @(negedge clk);
    rst = r; pipe_we = we; pipe_rd = prd; pipe_data = pd;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
    if (r) begin
      q.delete();
      exp_we = 0; exp_rd = '0; exp_data = '0;
    end else begin
      eff = we && prd != 0;
      acc = mv && q.size() < DEPTH;
      exp_we = 0;
      if (eff) begin
        exp_we = 1; exp_rd = prd; exp_data = pd;
      end else if (q.size() > 0 && q[0].v) begin
        exp_we = 1; exp_rd = q[0].rd; exp_data = q[0].data;
      end
      if (exp_we) exp_q.push_back('{rd: exp_rd, data: exp_data});
      drain = q.size() > 0 && (!q[0].v || !eff);
      if (eff) foreach (q[i]) if (q[i].rd == prd) q[i].v = 1'b0;
      if (drain) void'(q.pop_front());
      if (acc) begin
        e.rd = mrd; e.data = md; e.v = (mrd != 0) && !(eff && prd == mrd);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("regwrite", {31'd0, regwrite}, {31'd0, exp_we});
    check("wrreg_hold", {27'd0, wrreg}, {27'd0, exp_rd});
    check("wrdata_hold", wrdata, exp_data);
    check("fifo_count", {29'd0, fifo_count}, q.size());
    check("mc_ready", {31'd0, mc_ready}, {31'd0, q.size() < DEPTH});
    check("pending_mask", pending_mask, model_mask());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every asserted regwrite must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (regwrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: write r%0d=0x%08h with none expected", wrreg, wrdata);
        end else begin
          w = exp_q.pop_front();
          check("sb_wrreg", {27'd0, wrreg}, {27'd0, w.rd});
          check("sb_wrdata", wrdata, w.data);
        end
      end
    end
  end

  initial begin
    rst = 1; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Single pipeline write then idle.
    step(1, 5, 32'hAAAA0001, 0, 0, 0, 0);
    idle(1);
    // Two buffered results while the pipeline owns the port, then drain.
    step(1, 7, 32'h7777, 1, 3, 32'h11, 0);
    step(1, 8, 32'h8888, 1, 4, 32'h22, 0);
    step(1, 9, 32'h9999, 1, 6, 32'h33, 0);
    idle(3);
    // Buffered r9 overtaken by pipeline r9.
    step(1, 1, 32'h1, 1, 9, 32'h55, 0);
    step(1, 9, 32'h99, 0, 0, 0, 0);
    idle(2);
    // Same-cycle push and pipeline write to r6.
    step(1, 6, 32'h600D, 1, 6, 32'hBAD, 0);
    idle(2);
    // r0 from both sides.
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0);
    idle(2);
    // Reset with two pending entries.
    step(1, 2, 32'h2, 1, 10, 32'hA, 0);
    step(1, 2, 32'h3, 1, 11, 32'hB, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Randomized traffic over a small register set to force collisions.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 3);
    end
    idle(DEPTH + 3);
    done = 1;
    @(posedge clk);
    #2;
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
